// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word reads over req/ack,
// and queues {pc, instr} pairs for decode behind a valid/ready interface.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           DATA_W   = 32,
  parameter int unsigned           DEPTH    = 2,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0] r_q_pc    [DEPTH];
  logic [DATA_W-1:0] r_q_instr [DEPTH];

  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_nxt;
  logic              w_space;

  // Space is judged on the occupancy after this cycle's push/pop/flush.
  always_comb begin
    w_ack       = mem_ack & r_mem_req;
    w_push      = (r_state == S_REQ) & w_ack & ~redirect_valid;
    w_pop       = (r_count != '0) & if_ready & ~redirect_valid;
    w_count_nxt = redirect_valid ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    w_space     = (w_count_nxt < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= redirect_pc;
            r_fetch_pc <= redirect_pc;
          end else if (w_space) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            // Without ack the request must stay stable, so its response is drained later.
            if (w_ack) r_mem_addr <= redirect_pc;
            else       r_state    <= S_DRAIN;
          end else if (w_ack) begin
            r_fetch_pc <= r_mem_addr + ADDR_W'(1);
            if (w_space) begin
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end else begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (redirect_valid) r_fetch_pc <= redirect_pc;
          if (w_ack) begin
            r_state    <= S_REQ;
            r_mem_addr <= redirect_valid ? redirect_pc : r_fetch_pc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_mem_addr;
      r_q_instr[r_wr_ptr] <= mem_rdata;
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign if_valid = (r_count != '0);
  assign if_pc    = r_q_pc[r_rd_ptr];
  assign if_instr = r_q_instr[r_rd_ptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked
// against a stream model (contiguous PCs from the last redirect, instr = memf(pc)).
module tb_instr_fetch_unit;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_ready = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  instr_fetch_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (DEP),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_ready      (if_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  assign mem_rdata = memf(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] p_addr;
    logic          p_req, p_ack, p_redir;
    bit            seen;

    // Reset state
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", if_valid, 0);

    // Streaming at full rate
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stream_req", mem_req, 1);
      chk("stream_addr", mem_addr, 64'(k));
      if (k == 0) begin
        chk("stream_valid0", if_valid, 0);
      end else begin
        chk("stream_valid", if_valid, 1);
        chk("stream_pc", if_pc, 64'(k - 1));
        chk("stream_instr", if_instr, 64'(memf(AW'(k - 1))));
      end
    end

    // Backpressure fills the queue, then resumes
    do_reset();
    mem_ack = 1'b1;
    if_ready = 1'b0;
    step();
    chk("bp_addr0", mem_addr, 0);
    chk("bp_valid0", if_valid, 0);
    step();
    chk("bp_addr1", mem_addr, 1);
    chk("bp_pc0", if_pc, 0);
    step();
    chk("bp_req_fall", mem_req, 0);
    chk("bp_valid_full", if_valid, 1);
    chk("bp_pc_hold", if_pc, 0);
    step();
    chk("bp_req_idle", mem_req, 0);
    chk("bp_pc_hold2", if_pc, 0);
    if_ready = 1'b1;
    step();
    chk("bp_req_resume", mem_req, 1);
    chk("bp_addr_resume", mem_addr, 2);
    chk("bp_pc1", if_pc, 1);
    chk("bp_instr1", if_instr, 64'(memf(AW'(1))));

    // Redirect during a waiting request
    do_reset();
    mem_ack = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h5;
    step();
    chk("dr_req", mem_req, 1);
    chk("dr_addr5", mem_addr, 5);
    redirect_pc = 32'h40;
    step();
    chk("dr_hold1", mem_addr, 5);
    chk("dr_req1", mem_req, 1);
    redirect_valid = 1'b0;
    step();
    chk("dr_hold2", mem_addr, 5);
    mem_ack = 1'b1;
    step();
    chk("dr_new_addr", mem_addr, 32'h40);
    chk("dr_valid_drop", if_valid, 0);
    step();
    chk("dr_pc40", if_pc, 32'h40);
    chk("dr_instr40", if_instr, 64'(memf(32'h40)));

    // Redirect colliding with ack and pop
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    chk("col_valid", if_valid, 0);
    chk("col_addr", mem_addr, 32'h100);
    redirect_valid = 1'b0;
    step();
    chk("col_pc", if_pc, 32'h100);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    chk("wrap_valid0", if_valid, 0);
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFF);
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc_max", if_pc, 32'hFFFF_FFFF);
    chk("wrap_addr0", mem_addr, 0);
    step();
    chk("wrap_pc0", if_pc, 0);
    step();
    chk("wrap_pc1", if_pc, 1);

    // Asynchronous reset mid-wait
    mem_ack = 1'b0;
    step();
    chk("ar_req_before", mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_req", mem_req, 0);
    chk("ar_valid", if_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    step();
    chk("ar_restart_addr", mem_addr, 0);
    step();
    chk("ar_restart_pc", if_pc, 0);

    // Randomized run against the stream model
    do_reset();
    exp_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      mem_ack = ($urandom % 4) != 0;
      if_ready = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 40) == 0;
      redirect_pc = ($urandom % 2 != 0) ? AW'($urandom) : (32'hFFFF_FFFF - AW'($urandom % 3));
      if (if_valid && if_ready && !redirect_valid) begin
        chk("rnd_pc", if_pc, 64'(exp_pc));
        chk("rnd_instr", if_instr, 64'(memf(if_pc)));
        exp_pc = exp_pc + 1;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      p_req = mem_req;
      p_addr = mem_addr;
      p_ack = mem_ack;
      p_redir = redirect_valid;
      step();
      if (p_req && !p_ack) begin
        chk("rnd_req_stable", mem_req, 1);
        chk("rnd_addr_stable", mem_addr, 64'(p_addr));
      end
      if (p_redir) chk("rnd_flush", if_valid, 0);
    end

    // Drain at full rate: head must appear within a bound, then no bubbles
    redirect_valid = 1'b0;
    mem_ack = 1'b1;
    if_ready = 1'b1;
    seen = 0;
    for (int w = 0; w < 10 && !seen; w++) begin
      if (if_valid) seen = 1;
      else step();
    end
    chk("final_valid_timeout", seen, 1);
    for (int k = 0; k < 8; k++) begin
      chk("final_valid", if_valid, 1);
      chk("final_pc", if_pc, 64'(exp_pc));
      exp_pc = exp_pc + 1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Consumer side of the program-counter interface. Owns the fetch PC, issues word-addressed reads to instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small queue. Presents them to decode over a valid/ready interface. Sits between the PC/branch logic (redirect input) and the decode stage.

Parameters:
ADDR_W, 32, fetch PC / memory address width (word address; sequential PC steps by 1)
DATA_W, 32, instruction width
DEPTH, 2, fetch queue entries (power of 2, >= 2)
RESET_PC, 0, fetch PC value after reset

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
redirect_valid  input  1  load new fetch PC and flush queue
redirect_pc  input  ADDR_W  target word address
mem_req  output  1  memory read request (registered)
mem_addr  output  ADDR_W  read word address (registered)
mem_ack  input  1  read data valid this cycle; meaningful only while mem_req=1
mem_rdata  input  DATA_W  instruction word, valid with mem_ack
if_valid  output  1  queue head valid
if_instr  output  DATA_W  head instruction
if_pc  output  ADDR_W  head PC
if_ready  input  1  decode accepts head

Behaviour:
- One clock, asynchronous active-low reset. Reset: state=IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=0, queue empty, if_valid=0. if_instr and if_pc are don't-care while if_valid=0.
- Memory protocol: once mem_req=1, mem_req and mem_addr stay stable until the cycle mem_ack=1. Max one outstanding request. Ack may arrive in the first req cycle (zero-wait).
- Queue: FIFO of {pc, instr}, count 0..DEPTH. if_valid=(count!=0). Pop on if_valid&&if_ready. Push on accepted ack. Push and pop in the same cycle leave count unchanged.
- space = count - pop + push < DEPTH, evaluated on next-cycle values.
- States:
  - IDLE (mem_req=0): if redirect, or if space with no redirect, -> REQ with mem_req<=1 and mem_addr<=fetch_pc, or redirect_pc when redirecting.
  - REQ: on ack without redirect, push {mem_addr, mem_rdata} and fetch_pc<=mem_addr+1. If space remains, stay in REQ with mem_addr<=mem_addr+1 (back-to-back). Otherwise go to IDLE with mem_req<=0.
  - DRAIN (mem_req=1, response to be discarded): on ack, drop data and -> REQ with mem_addr<=fetch_pc.
- Throughput: with mem_ack held high and if_ready=1, one instruction per cycle is sustained. Latency from first mem_ack to if_valid is 1 cycle.
- Redirect always has priority and flushes the queue (count<=0). Any same-cycle pop is ignored and if_valid=0 next cycle. fetch_pc<=redirect_pc.
  - In IDLE: -> REQ, mem_addr<=redirect_pc.
  - In REQ with no ack: -> DRAIN. mem_req and mem_addr stay unchanged (protocol stability).
  - In REQ with ack: data is discarded. -> REQ with mem_addr<=redirect_pc.
  - In DRAIN: fetch_pc updated, stay in DRAIN. If ack arrives the same cycle -> REQ with mem_addr<=redirect_pc.
- Arithmetic: PC increment is modulo 2^ADDR_W. 2^ADDR_W-1 wraps to 0 silently.
- Full queue: no request is issued. mem_req falls only after the ack that fills the queue, never mid-request.
- Reset asserted mid-request forces mem_req=0 immediately (async). Memory must abandon the transaction.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset release, RESET_PC=0, mem_ack=1 every cycle, if_ready=1 -> mem_addr 0,1,2,3 on consecutive cycles. if_pc/if_instr appear 1 cycle after each ack, in order, with no bubbles.
- if_ready=0, mem_ack=1 -> exactly DEPTH=2 pushes (pc 0,1), then mem_req=0 and if_valid=1 holding pc 0. Raise if_ready -> pop pc 0, mem_req reasserts with mem_addr=2.
- Request at addr 5 with 3-cycle ack delay, redirect_pc=0x40 on wait cycle 1 -> mem_addr stays 5 until ack, data discarded, next mem_addr=0x40. Next if_pc=0x40; no pc 5 ever emitted.
- redirect_valid=1 with mem_ack=1 and if_valid&&if_ready same cycle -> queue flushed, acked data dropped, if_valid=0 next cycle, mem_addr=redirect_pc.
- redirect_pc=0xFFFFFFFF, acks every cycle -> if_pc sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
- reset_n pulsed low mid-wait, no clock edge -> mem_req=0 and if_valid=0 immediately. After release, fetch restarts at RESET_PC.
